piezo_event_timestamper: RTL and testbench

- Captures PTP-time timestamps of external piezo event-trigger edges and buffers them in a FIFO.
- Exposes the buffered timestamps to the soft CPU through a small Avalon-MM slave.
- Sits downstream of the PTP time source, which supplies the free-running `time_now`.
- Sits upstream of the RTC/event conduit logic, which consumes `piezo_enable` and `flag_allow_read`.

---
 rtl/piezo_event_timestamper_if.sv | 31 +++
 rtl/piezo_event_timestamper.sv | 195 +++++++++++++++++++
 tb/tb_piezo_event_timestamper.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piezo_event_timestamper_if.sv
`default_nettype none
// ============================================================================
// Module   : piezo_event_timestamper_if
// Brief    : Avalon-MM slave bus bundle for the piezo event timestamper.
// Revision : 1.0 - initial release
// ============================================================================
interface piezo_event_timestamper_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;

  // CPU side drives the strobes, the block returns read data
  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface
`default_nettype wire

// File: rtl/piezo_event_timestamper.sv
`default_nettype none
// ============================================================================
// Module   : piezo_event_timestamper
// Brief    : Debounced capture of PTP timestamps on piezo trigger edges,
//            buffered in a FIFO and read back over an Avalon-MM slave.
// Revision : 1.0 - initial release
// ============================================================================
module piezo_event_timestamper #(
  parameter int TIME_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DEBOUNCE   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [TIME_W-1:0]         time_now,
  input  logic                      event_trigger,
  output logic                      piezo_enable,
  output logic                      flag_allow_read,
  output logic                      overflow,
  piezo_event_timestamper_if.slave  avs
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1) + 1;

  localparam logic [AW:0]   c_FULL      = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   c_PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] c_CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  // Last qualify count before the push: the edge cycle itself counts as one
  localparam logic [CW-1:0] c_QUAL_LAST = CW'(DEBOUNCE - 1);

  localparam logic [1:0] c_ADDR_DATA   = 2'd0;
  localparam logic [1:0] c_ADDR_STATUS = 2'd1;
  localparam logic [1:0] c_ADDR_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_QUALIFY = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  logic              sync1_q, s_q, s_d_q;
  state_t            state_q;
  logic [TIME_W-1:0] ts_q;
  logic [CW-1:0]     cnt_q;
  logic              piezo_enable_q;

  logic              arm_q, arm_d;
  logic              overflow_q, overflow_d;
  logic              flag_q, flag_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [TIME_W-1:0] mem [FIFO_DEPTH];

  logic w_ctrl_wr, w_clr_ovf, w_flush, w_rise, w_push, w_pop;
  logic w_push_ok, w_ovf_set;
  logic w_unused;

  assign w_unused = ^avs.avs_writedata[31:3];

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      s_d_q   <= 1'b0;
    end else begin
      sync1_q <= event_trigger;
      s_q     <= sync1_q;
      s_d_q   <= s_q;
    end
  end

  // Bus decode and event strobes; arm_d lets a disarm cancel a same-cycle push
  always_comb begin
    w_ctrl_wr = avs.avs_write && (avs.avs_address == c_ADDR_CTRL);
    arm_d     = w_ctrl_wr ? avs.avs_writedata[0] : arm_q;
    w_clr_ovf = w_ctrl_wr && avs.avs_writedata[1];
    w_flush   = w_ctrl_wr && avs.avs_writedata[2];
    w_rise    = s_q && !s_d_q;
    w_push    = (state_q == S_QUALIFY) && s_q && (cnt_q >= c_QUAL_LAST) && arm_d;
    w_pop     = avs.avs_read && (avs.avs_address == c_ADDR_DATA) && (count_q != '0);
  end

  // Capture FSM: arm, latch on edge, debounce, hold off until the input drops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ts_q           <= '0;
      cnt_q          <= '0;
      piezo_enable_q <= 1'b0;
    end else if (!arm_d) begin
      state_q        <= S_IDLE;
      piezo_enable_q <= 1'b0;
    end else begin
      piezo_enable_q <= 1'b1;
      case (state_q)
        S_IDLE: state_q <= S_ARMED;
        S_ARMED: begin
          if (w_rise) begin
            ts_q    <= time_now;
            cnt_q   <= c_CNT_ONE;
            state_q <= S_QUALIFY;
          end
        end
        S_QUALIFY: begin
          if (!s_q) begin
            state_q <= S_ARMED;
          end else if (cnt_q >= c_QUAL_LAST) begin
            state_q <= S_HOLDOFF;
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
          end
        end
        S_HOLDOFF: begin
          if (!s_q) state_q <= S_ARMED;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO pointer/count update; flush beats any push, a full push needs a pop
  always_comb begin
    w_push_ok  = w_push && !w_flush && ((count_q != c_FULL) || w_pop);
    w_ovf_set  = w_push && !w_flush && (count_q == c_FULL) && !w_pop;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (w_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (w_push_ok) wptr_d = wptr_q + c_PTR_ONE;
      if (w_pop)     rptr_d = rptr_q + c_PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   count_d = count_q + c_PTR_ONE;
        2'b01:   count_d = count_q - c_PTR_ONE;
        default: count_d = count_q;
      endcase
    end
    overflow_d = w_ovf_set || (overflow_q && !w_clr_ovf);
    flag_d     = (count_d != '0);
  end

  // Registered read mux, zero when idle or unmapped
  always_comb begin
    readdata_d = '0;
    if (avs.avs_read) begin
      case (avs.avs_address)
        c_ADDR_DATA:   if (count_q != '0) readdata_d = 32'(mem[rptr_q[AW-1:0]]);
        c_ADDR_STATUS: readdata_d = {16'(count_q), 13'd0, arm_q, overflow_q, (count_q == '0)};
        c_ADDR_CTRL:   readdata_d = {31'd0, arm_q};
        default:       readdata_d = '0;
      endcase
    end
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q      <= 1'b0;
      overflow_q <= 1'b0;
      flag_q     <= 1'b0;
      readdata_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      arm_q      <= arm_d;
      overflow_q <= overflow_d;
      flag_q     <= flag_d;
      readdata_q <= readdata_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Timestamp storage; contents are only visible through the gated read path
  always_ff @(posedge clk) begin
    if (w_push_ok) mem[wptr_q[AW-1:0]] <= ts_q;
  end

  assign piezo_enable     = piezo_enable_q;
  assign flag_allow_read  = flag_q;
  assign overflow         = overflow_q;
  assign avs.avs_readdata = readdata_q;

endmodule
`default_nettype wire

// File: tb/tb_piezo_event_timestamper.sv
`default_nettype none
// ============================================================================
// Module   : tb_piezo_event_timestamper
// Brief    : Self-checking bench for piezo_event_timestamper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piezo_event_timestamper;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] time_now;
  logic        event_trigger;
  logic        piezo_enable;
  logic        flag_allow_read;
  logic        overflow;

  piezo_event_timestamper_if bus ();

  piezo_event_timestamper #(
    .TIME_W     (32),
    .FIFO_DEPTH (8),
    .DEBOUNCE   (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .time_now        (time_now),
    .event_trigger   (event_trigger),
    .piezo_enable    (piezo_enable),
    .flag_allow_read (flag_allow_read),
    .overflow        (overflow),
    .avs             (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  typedef struct {
    int          width;
    bit          pushes;
    logic [15:0] exp_count;
  } vec_t;
  vec_t vecs [5];

  // Advance one clock; time_now steps by one per cycle
  task automatic tick();
    @(posedge clk);
    #1;
    time_now = time_now + 32'd1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  // Pin pulse of w cycles; a qualifying pulse records time at pin edge + 2
  task automatic do_pulse(input int w, input bit record);
    logic [31:0] t;
    t = time_now + 32'd2;
    if (record) sb.push_back(t);
    event_trigger = 1'b1;
    repeat (w) tick();
    event_trigger = 1'b0;
    repeat (8) tick();
  endtask

  task automatic drain_one(input string name);
    logic [31:0] d, e;
    bus_read(2'd0, d);
    e = (sb.size() > 0) ? sb.pop_front() : 32'd0;
    chk(name, d, e);
  endtask

  initial begin
    logic [31:0] d, t, e;

    vecs[0] = '{width: 1, pushes: 1'b0, exp_count: 16'd0};
    vecs[1] = '{width: 2, pushes: 1'b0, exp_count: 16'd0};
    vecs[2] = '{width: 3, pushes: 1'b0, exp_count: 16'd0};
    vecs[3] = '{width: 4, pushes: 1'b1, exp_count: 16'd1};
    vecs[4] = '{width: 7, pushes: 1'b1, exp_count: 16'd2};

    reset             = 1'b1;
    event_trigger     = 1'b0;
    time_now          = 32'd0;
    bus.avs_address   = 2'd0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'd0;

    // Reset state
    repeat (3) tick();
    chk("rst_enable", {31'd0, piezo_enable}, 32'd0);
    chk("rst_flag", {31'd0, flag_allow_read}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_rdata", bus.avs_readdata, 32'd0);
    reset = 1'b0;
    tick();
    bus_read(2'd1, d);
    chk("rst_status", d, 32'h0000_0001);

    // Arm
    bus_write(2'd2, 32'd1);
    tick();
    chk("arm_enable", {31'd0, piezo_enable}, 32'd1);
    bus_read(2'd2, d);
    chk("arm_readback", d, 32'd1);

    // Single 10-cycle event with flag timing
    time_now = 32'h0000_1000;
    sb.push_back(32'h0000_1002);
    event_trigger = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 5) chk("flag_early", {31'd0, flag_allow_read}, 32'd0);
      if (k == 6) chk("flag_rise", {31'd0, flag_allow_read}, 32'd1);
    end
    event_trigger = 1'b0;
    repeat (8) tick();
    bus_read(2'd1, d);
    chk("one_status", d, 32'h0001_0004);
    drain_one("one_ts");
    bus_read(2'd1, d);
    chk("one_empty", d, 32'h0000_0005);

    // Glitch widths table
    for (int i = 0; i < 5; i++) begin
      do_pulse(vecs[i].width, vecs[i].pushes);
      bus_read(2'd1, d);
      chk($sformatf("glitch_w%0d_count", vecs[i].width), {16'd0, d[31:16]}, {16'd0, vecs[i].exp_count});
    end
    drain_one("glitch_ts0");
    drain_one("glitch_ts1");

    // Raw copy across time wrap
    time_now = 32'hFFFF_FFFD;
    do_pulse(5, 1'b1);
    drain_one("wrap_ts");

    // Fill past depth: ninth event dropped, overflow sticky
    for (int i = 0; i < 9; i++) do_pulse(5, i < 8);
    bus_read(2'd1, d);
    chk("full_status", d, 32'h0008_0006);
    chk("full_ovf", {31'd0, overflow}, 32'd1);
    bus_write(2'd2, 32'd3);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    bus_read(2'd1, d);
    chk("clr_status", d, 32'h0008_0004);

    // Push and pop on the same edge while full
    t = time_now + 32'd2;
    event_trigger = 1'b1;
    repeat (5) tick();
    event_trigger   = 1'b0;
    bus.avs_address = 2'd0;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read = 1'b0;
    e = sb.pop_front();
    chk("pushpop_ts", bus.avs_readdata, e);
    sb.push_back(t);
    repeat (6) tick();
    chk("pushpop_ovf", {31'd0, overflow}, 32'd0);
    bus_read(2'd1, d);
    chk("pushpop_status", d, 32'h0008_0004);
    for (int i = 0; i < 8; i++) drain_one($sformatf("drain_%0d", i));
    bus_read(2'd1, d);
    chk("drain_status", d, 32'h0000_0005);
    drain_one("empty_read");
    bus_read(2'd1, d);
    chk("empty_status", d, 32'h0000_0005);

    // Disarm mid-qualify
    event_trigger = 1'b1;
    repeat (4) tick();
    bus_write(2'd2, 32'd0);
    chk("disarm_enable", {31'd0, piezo_enable}, 32'd0);
    repeat (4) tick();
    event_trigger = 1'b0;
    repeat (8) tick();
    bus_read(2'd1, d);
    chk("disarm_status", d, 32'h0000_0001);

    // Flush with five entries
    bus_write(2'd2, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) do_pulse(5, 1'b0);
    bus_read(2'd1, d);
    chk("preflush_status", d, 32'h0005_0004);
    chk("preflush_flag", {31'd0, flag_allow_read}, 32'd1);
    bus_write(2'd2, 32'd5);
    chk("flush_flag", {31'd0, flag_allow_read}, 32'd0);
    bus_read(2'd1, d);
    chk("flush_status", d, 32'h0000_0005);

    // Reset with three entries and the FSM in holdoff
    do_pulse(5, 1'b0);
    do_pulse(5, 1'b0);
    event_trigger = 1'b1;
    repeat (8) tick();
    chk("prereset_flag", {31'd0, flag_allow_read}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mreset_enable", {31'd0, piezo_enable}, 32'd0);
    chk("mreset_flag", {31'd0, flag_allow_read}, 32'd0);
    chk("mreset_ovf", {31'd0, overflow}, 32'd0);
    event_trigger = 1'b0;
    tick();
    bus_read(2'd1, d);
    chk("mreset_status", d, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
